multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 74 +++++++
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/multicycle_controller_alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 149 ++++++++++++++
 tb/tb_multicycle_controller.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V control unit:
// FSM states, ALU opcodes, datapath selects and base opcodes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB,
        S_BRANCH, S_JALRADR, S_JUMP, S_LUI
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_XOR = 3'b101
    } alu_ctl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10,
        RES_IMMEXT    = 2'b11
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    function automatic imm_src_t imm_src_of(input logic [6:0] op);
        imm_src_t r;
        case (op)
            OP_STORE:  r = IMM_S;
            OP_BRANCH: r = IMM_B;
            OP_JAL:    r = IMM_J;
            OP_LUI:    r = IMM_U;
            default:   r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between datapath (master) and controller (slave).
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       sign;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [2:0] ALUControl;

    modport master (
        output op, funct3, funct7b5, Zero, sign,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );

    modport slave (
        input  op, funct3, funct7b5, Zero, sign,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus instruction fields
// to the ALU operation select.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output alu_ctl_t   o_alu_ctl
);

    always_comb begin
        o_alu_ctl = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // only R-type sub sets bit 30; addi may carry it in imm
                    3'b000: o_alu_ctl = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010: o_alu_ctl = ALU_SLT;
                    3'b100: o_alu_ctl = ALU_XOR;
                    3'b110: o_alu_ctl = ALU_OR;
                    3'b111: o_alu_ctl = ALU_AND;
                    default: o_alu_ctl = ALU_ADD;
                endcase
            end
            default: o_alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32I datapath; all
// outputs are forced to zero while reset is held.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.slave  io_ctl
);

    state_t      r_state;
    state_t      w_next;
    alu_op_t     w_alu_op;
    alu_ctl_t    w_alu_ctl;
    result_src_t w_result;
    src_a_t      w_src_a;
    src_b_t      w_src_b;
    imm_src_t    w_imm;
    logic        w_pcwrite;
    logic        w_adrsrc;
    logic        w_memwrite;
    logic        w_irwrite;
    logic        w_regwrite;
    logic        w_taken;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        case (io_ctl.funct3)
            3'b000:  w_taken = io_ctl.Zero;
            3'b001:  w_taken = ~io_ctl.Zero;
            3'b100:  w_taken = io_ctl.sign;
            3'b101:  w_taken = ~io_ctl.sign;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = S_FETCH;
        w_alu_op   = ALUOP_ADD;
        w_result   = RES_ALUOUT;
        w_src_a    = SRCA_PC;
        w_src_b    = SRCB_RS2;
        w_pcwrite  = 1'b0;
        w_adrsrc   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_src_b   = SRCB_FOUR;
                w_result  = RES_ALURESULT;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
                case (io_ctl.op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:  w_next = S_EXECUTER;
                    OP_ITYPE:  w_next = S_EXECUTEI;
                    OP_BRANCH: w_next = S_BRANCH;
                    OP_JAL:    w_next = S_JUMP;
                    OP_JALR:   w_next = S_JALRADR;
                    OP_LUI:    w_next = S_LUI;
                    default:   w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
                w_next  = (io_ctl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = S_MEMWB;
            end
            S_MEMWB: begin
                w_result   = RES_DATA;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                w_src_a  = SRCA_RS1;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_ALUWB: w_regwrite = 1'b1;
            S_BRANCH: begin
                w_src_a   = SRCA_RS1;
                w_alu_op  = ALUOP_SUB;
                w_pcwrite = w_taken;
            end
            S_JALRADR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
                w_next  = S_JUMP;
            end
            // PC <= target held in ALUOut while ALU forms OldPC+4 for rd
            S_JUMP: begin
                w_src_a   = SRCA_OLDPC;
                w_src_b   = SRCB_FOUR;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_LUI: begin
                w_result   = RES_IMMEXT;
                w_regwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign w_imm = imm_src_of(io_ctl.op);

    alu_decoder u_alu_dec (
        .i_alu_op   (w_alu_op),
        .i_funct3   (io_ctl.funct3),
        .i_op5      (io_ctl.op[5]),
        .i_funct7b5 (io_ctl.funct7b5),
        .o_alu_ctl  (w_alu_ctl)
    );

    assign io_ctl.PCWrite    = rst_n & w_pcwrite;
    assign io_ctl.AdrSrc     = rst_n & w_adrsrc;
    assign io_ctl.MemWrite   = rst_n & w_memwrite;
    assign io_ctl.IRWrite    = rst_n & w_irwrite;
    assign io_ctl.RegWrite   = rst_n & w_regwrite;
    assign io_ctl.ResultSrc  = rst_n ? w_result  : 2'b00;
    assign io_ctl.ALUSrcA    = rst_n ? w_src_a   : 2'b00;
    assign io_ctl.ALUSrcB    = rst_n ? w_src_b   : 2'b00;
    assign io_ctl.ImmSrc     = rst_n ? w_imm     : 3'b000;
    assign io_ctl.ALUControl = rst_n ? w_alu_ctl : 3'b000;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-cycle expected control vectors from an
// instruction-level model, checked by a negedge monitor.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_ctl (bus.slave)
    );

    typedef logic [16:0] vec_t;

    vec_t  q_exp[$];
    string q_tag[$];
    int    n_chk = 0;
    int    n_bad = 0;

    function automatic vec_t mk(input bit pcw, input bit adr, input bit mw,
                                input bit irw, input bit rw, input bit [1:0] rs,
                                input bit [1:0] sa, input bit [1:0] sb,
                                input bit [2:0] im, input bit [2:0] alu);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, im, alu};
    endfunction

    function automatic bit [2:0] imm_of(input bit [6:0] op);
        case (op)
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b1101111: return 3'd3;
            7'b0110111: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    // ALU operation an R/I instruction requests
    function automatic bit [2:0] alu_of(input bit [6:0] op, input bit [2:0] f3,
                                        input bit f7);
        case (f3)
            3'd0: return (op[5] && f7) ? 3'd1 : 3'd0;
            3'd2: return 3'd4;
            3'd4: return 3'd5;
            3'd6: return 3'd3;
            3'd7: return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic bit taken_of(input bit [2:0] f3, input bit z, input bit s);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return s;
            3'd5: return !s;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input vec_t v, input string tag);
        q_exp.push_back(v);
        q_tag.push_back(tag);
    endtask

    // Expected control vector for every cycle of one instruction
    task automatic model(input bit [6:0] op, input bit [2:0] f3, input bit f7,
                         input bit z, input bit s, input string tag,
                         output int n);
        bit [2:0] im;
        im = imm_of(op);
        push(mk(1,0,0,1,0,2,0,2,im,0), {tag, ":fetch"});
        push(mk(0,0,0,0,0,0,1,1,im,0), {tag, ":decode"});
        n = 2;
        case (op)
            7'b0000011: begin
                push(mk(0,0,0,0,0,0,2,1,im,0), {tag, ":adr"});
                push(mk(0,1,0,0,0,0,0,0,im,0), {tag, ":rd"});
                push(mk(0,0,0,0,1,1,0,0,im,0), {tag, ":wb"});
                n = 5;
            end
            7'b0100011: begin
                push(mk(0,0,0,0,0,0,2,1,im,0), {tag, ":adr"});
                push(mk(0,1,1,0,0,0,0,0,im,0), {tag, ":wr"});
                n = 4;
            end
            7'b0110011, 7'b0010011: begin
                push(mk(0,0,0,0,0,0,2,(op[5] ? 2'd0 : 2'd1),im,alu_of(op,f3,f7)),
                     {tag, ":exe"});
                push(mk(0,0,0,0,1,0,0,0,im,0), {tag, ":wb"});
                n = 4;
            end
            7'b1100011: begin
                push(mk(taken_of(f3,z,s),0,0,0,0,0,2,0,im,1), {tag, ":br"});
                n = 3;
            end
            7'b1101111, 7'b1100111: begin
                if (op == 7'b1100111) begin
                    push(mk(0,0,0,0,0,0,2,1,im,0), {tag, ":jadr"});
                    n = n + 1;
                end
                push(mk(1,0,0,0,0,0,1,2,im,0), {tag, ":jump"});
                push(mk(0,0,0,0,1,0,0,0,im,0), {tag, ":wb"});
                n = n + 2;
            end
            7'b0110111: begin
                push(mk(0,0,0,0,1,3,0,0,im,0), {tag, ":lui"});
                n = 3;
            end
            default: n = 2;
        endcase
    endtask

    task automatic run(input bit [6:0] op, input bit [2:0] f3, input bit f7,
                       input bit z, input bit s, input string tag);
        int n;
        bus.op = op;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        bus.Zero = z;
        bus.sign = s;
        model(op, f3, f7, z, s, tag, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            vec_t  e;
            vec_t  a;
            string t;
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            a = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                 bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                 bus.ImmSrc, bus.ALUControl};
            n_chk++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s got=%05h want=%05h", t, a, e);
            end
        end
    end

    localparam bit [6:0] OPS [8] = '{7'b0000011, 7'b0100011, 7'b0110011,
        7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

    initial begin
        int wait_cyc;
        bit [6:0] rop;
        bus.op = 7'd0;
        bus.funct3 = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0;
        bus.sign = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        push('0, "reset0");
        push('0, "reset1");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(7'b0110011, 3'd0, 1'b0, 0, 0, "add");
        run(7'b0110011, 3'd0, 1'b1, 0, 0, "sub");
        run(7'b0010011, 3'd0, 1'b1, 0, 0, "addi_f7");
        run(7'b1100011, 3'd0, 1'b0, 1, 0, "beq_z");
        run(7'b1100011, 3'd1, 1'b0, 1, 0, "bne_z");
        run(7'b1100011, 3'd4, 1'b0, 0, 1, "blt_s");
        run(7'b1100011, 3'd5, 1'b0, 0, 1, "bge_s");
        run(7'b1100111, 3'd0, 1'b0, 0, 0, "jalr");
        run(7'b1101111, 3'd0, 1'b0, 0, 0, "jal");
        run(7'b0000000, 3'd0, 1'b0, 0, 0, "illegal");
        run(7'b0110111, 3'd0, 1'b0, 0, 0, "lui");
        run(7'b0000011, 3'd2, 1'b0, 0, 0, "lw");
        run(7'b0100011, 3'd2, 1'b0, 0, 0, "sw");

        // reset landing in the MEMREAD cycle of a load
        bus.op = 7'b0000011;
        bus.funct3 = 3'd2;
        push(mk(1,0,0,1,0,2,0,2,0,0), "rstlw:fetch");
        push(mk(0,0,0,0,0,0,1,1,0,0), "rstlw:decode");
        push(mk(0,0,0,0,0,0,2,1,0,0), "rstlw:adr");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        push('0, "rstlw:inreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(7'b0000011, 3'd2, 1'b0, 0, 0, "after_rst");

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) rop = 7'($urandom);
            else rop = OPS[$urandom_range(0, 7)];
            run(rop, 3'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), $sformatf("rnd%0d", i));
        end

        wait_cyc = 0;
        while (q_exp.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q_exp.size() > 0) begin
            n_bad++;
            $display("FAIL drain left=%0d want=0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
